md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide sequencer for the 5-stage pipeline, instantiated in the E stage next to the ALU.
- Owns the HI/LO register pair.
  - Accepts mult/multu/div/divu/mthi/mtlo from E.
  - Models multi-cycle latency with a busy counter.
  - Raises a stall request toward the D-stage hazard logic while a later HI/LO-using instruction must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (>=1).
- DIV_CYCLES, 10, busy cycles after a div/divu start (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is a valid md operation this cycle.
- md_op  input  3  operation code (see package).
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- d_md_use  input  1  D-stage instruction is any md op, or mfhi/mflo.
- busy  output  1  multi-cycle operation in progress.
- md_stall  output  1  stall request to hazard unit (combinational).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, counter=0, pending result regs=0. Reset mid-operation aborts it; HI/LO are not written.
- States: IDLE (counter==0), BUSY (counter>0). busy = (counter != 0), registered.
- start sampled at edge T with md_op:
  - MULT, MULTU: 64-bit product computed combinationally from a/b and latched into pending_hi/pending_lo; counter loaded with MULT_CYCLES; busy=1 from T+1.
  - DIV, DIVU: quotient into pending_lo, remainder into pending_hi; counter loaded with DIV_CYCLES.
  - MTHI or MTLO: hi or lo := a at edge T; no busy; counter untouched.
  - NONE, or an undefined code (7): ignored.
- Completion: at each edge with counter>0, counter decrements. At the edge where counter goes 1→0, hi/lo := pending values and busy falls. MULT_CYCLES=5 means busy is high for exactly 5 cycles, and new hi/lo are visible in the first cycle busy is low.
- Arithmetic:
  - MULT: signed 32x32→64; HI = upper word, LO = lower word. MULTU: unsigned.
  - DIV: signed; quotient truncates toward zero; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero (b==0): counter still loaded with DIV_CYCLES; HI/LO unchanged at completion.
- md_stall = d_md_use & (busy | (start & md_op in {MULT,MULTU,DIV,DIVU})).
- Protocol rule: start while busy=1 never occurs, because the hazard unit stalls via md_stall. If it does occur, it is ignored and the in-flight operation continues. The bench flags it as a protocol error.
- No flush input: once started, an operation always completes.

Decomposition:
- Shared package md_pkg:
  - md_op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Defaults for MULT_CYCLES/DIV_CYCLES.
- One natural sub-module: md_calc, purely combinational, computing {pending_hi, pending_lo} and a div-by-zero flag from md_op, a and b.
- md_unit holds the counter, pending registers, HI/LO and the stall logic.

Test Plan:
- MULT a=0xFFFFFFFF b=0x2 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo hold old values while busy.
- MULTU a=0xFFFFFFFF b=0x2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=0x2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 → busy 10 cycles; hi/lo unchanged.
- Stall: start MULT with d_md_use=1 → md_stall=1 in the start cycle and all 5 busy cycles, 0 on the cycle busy falls. d_md_use=0 → md_stall=0 throughout.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo update on the next edge each; busy stays 0.
- Reset asserted on the 3rd busy cycle of a DIV → next edge busy=0, hi=lo=0; no later HI/LO write.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } md_res_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage <-> md_unit signal bundle; master is the pipeline, slave the unit.
interface md_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, a, b, d_md_use,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  start, md_op, a, b, d_md_use,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_calc.sv
// Combinational product/quotient/remainder for one md op; latched by md_unit.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output md_res_t     o_res
);

  logic [63:0] w_smul, w_umul;
  logic        w_sgn, w_an, w_bn, w_bz;
  logic [31:0] w_ua, w_ub, w_ubs, w_uq, w_ur, w_q, w_r;

  assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly.
  assign w_sgn = (i_op == MD_DIV);
  assign w_an  = w_sgn & i_a[31];
  assign w_bn  = w_sgn & i_b[31];
  assign w_ua  = w_an ? -i_a : i_a;
  assign w_ub  = w_bn ? -i_b : i_b;
  assign w_bz  = (i_b == 32'd0);
  assign w_ubs = w_bz ? 32'd1 : w_ub;
  assign w_uq  = w_ua / w_ubs;
  assign w_ur  = w_ua % w_ubs;
  assign w_q   = (w_an ^ w_bn) ? -w_uq : w_uq;
  assign w_r   = w_an ? -w_ur : w_ur;

  always_comb begin
    o_res = '0;
    case (i_op)
      MD_MULT:         {o_res.hi, o_res.lo} = w_smul;
      MD_MULTU:        {o_res.hi, o_res.lo} = w_umul;
      MD_DIV, MD_DIVU: begin
        o_res.hi = w_r;
        o_res.lo = w_q;
        o_res.dz = w_bz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO owner: latches md results, models latency with a down-counter, raises md_stall.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  md_res_t     r_pend, w_pend_nxt, w_calc;
  logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;

  md_calc u_calc (
    .i_op  (md.md_op),
    .i_a   (md.a),
    .i_b   (md.b),
    .o_res (w_calc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // A start arriving while BUSY is dropped; the in-flight op runs to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (md.start) begin
          case (md.md_op)
            MD_MULT, MD_MULTU: begin
              w_pend_nxt  = w_calc;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              w_pend_nxt  = w_calc;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            MD_MTHI: w_hi_nxt = md.a;
            MD_MTLO: w_lo_nxt = md.a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          if (!r_pend.dz) begin
            w_hi_nxt = r_pend.hi;
            w_lo_nxt = r_pend.lo;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    md.busy     = (r_state == ST_BUSY);
    md.md_stall = md.d_md_use & ((r_state == ST_BUSY) | (md.start & is_long_op(md.md_op)));
    md.hi       = r_hi;
    md.lo       = r_lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: reference model pushes expected HI/LO, popped on completion.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if bus();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, proto_errs = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk)
    if (!reset && bus.start && bus.busy) begin
      proto_errs++;
      $display("protocol error: start while busy at %0t", $time);
    end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, h, l);
    longint sa, sb2;
    logic [63:0] r;
    r = {h, l};
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      MD_MULT:  r = 64'(sa * sb2);
      MD_MULTU: r = 64'(a) * 64'(b);
      MD_DIV:   if (b != 0) r = {32'(sa % sb2), 32'(sa / sb2)};
      MD_DIVU:  if (b != 0) r = {a % b, a / b};
      MD_MTHI:  r = {a, l};
      MD_MTLO:  r = {h, a};
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, b, input logic dmu,
                        output int bcyc, output int stall_cnt, output bit hold_ok,
                        output logic stall_start, output logic stall_after);
    logic [31:0] oh, ol;
    logic [63:0] e;
    exp_t x;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b; bus.d_md_use = dmu;
    #1 stall_start = bus.md_stall;
    oh = bus.hi; ol = bus.lo;
    e = model(op, a, b, m_hi, m_lo);
    x.hi = e[63:32]; x.lo = e[31:0];
    sb.push_back(x);
    m_hi = x.hi; m_lo = x.lo;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.md_op = MD_NONE;
    bcyc = 0; stall_cnt = 0; hold_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      bcyc++;
      if (bus.md_stall) stall_cnt++;
      if (bus.hi !== oh || bus.lo !== ol) hold_ok = 1'b0;
    end
    stall_after = bus.md_stall;
    bus.d_md_use = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.d_md_use = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.md_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", bus.md_stall); end
    reset = 1'b0; bus.d_md_use = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult;
    int bc, sc; bit ho; logic ss, sa; exp_t x;
    run_md(MD_MULT, 32'hFFFFFFFF, 32'h2, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (bc !== 5) begin miscompares++; $display("FAIL mult_busy: got %0d want 5", bc); end
    vectors++; if (!ho) begin miscompares++; $display("FAIL mult_hold: got changed want held"); end
    vectors++; if (bus.hi !== x.hi || x.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h want %h", bus.hi, x.hi); end
    vectors++; if (bus.lo !== x.lo || x.lo !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mult_lo: got %h want %h", bus.lo, x.lo); end
    vectors++; if (sc !== 0 || ss !== 1'b0) begin miscompares++; $display("FAIL mult_nostall: got %0d/%b want 0/0", sc, ss); end
  endtask

  task automatic test_multu;
    int bc, sc; bit ho; logic ss, sa; exp_t x;
    run_md(MD_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (bc !== 5) begin miscompares++; $display("FAIL multu_busy: got %0d want 5", bc); end
    vectors++; if (bus.hi !== x.hi || x.hi !== 32'h1) begin miscompares++; $display("FAIL multu_hi: got %h want %h", bus.hi, x.hi); end
    vectors++; if (bus.lo !== x.lo) begin miscompares++; $display("FAIL multu_lo: got %h want %h", bus.lo, x.lo); end
  endtask

  task automatic test_div;
    int bc, sc; bit ho; logic ss, sa; exp_t x;
    run_md(MD_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (bc !== 10) begin miscompares++; $display("FAIL div_busy: got %0d want 10", bc); end
    vectors++; if (bus.lo !== x.lo || x.lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo: got %h want %h", bus.lo, x.lo); end
    vectors++; if (bus.hi !== x.hi || x.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi: got %h want %h", bus.hi, x.hi); end
    run_md(MD_DIVU, 32'h7, 32'h0, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (bc !== 10) begin miscompares++; $display("FAIL divz_busy: got %0d want 10", bc); end
    vectors++; if (bus.hi !== x.hi || bus.lo !== x.lo || !ho) begin miscompares++; $display("FAIL divz_unchanged: got %h/%h want %h/%h", bus.hi, bus.lo, x.hi, x.lo); end
  endtask

  task automatic test_div_overflow;
    int bc, sc; bit ho; logic ss, sa; exp_t x;
    run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0 || x.lo !== 32'h80000000) begin
      miscompares++; $display("FAIL div_ovf: got %h/%h want %h/%h", bus.hi, bus.lo, x.hi, x.lo); end
  endtask

  task automatic test_mt;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MTHI; bus.a = 32'h12345678; bus.d_md_use = 1'b1;
    #1;
    vectors++; if (bus.md_stall !== 1'b0) begin miscompares++; $display("FAIL mthi_stall: got %b want 0", bus.md_stall); end
    @(negedge clk);
    vectors++; if (bus.hi !== 32'h12345678 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mthi: got %h busy %b want 12345678 busy 0", bus.hi, bus.busy); end
    bus.md_op = MD_MTLO; bus.a = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = MD_NONE; bus.d_md_use = 1'b0;
    vectors++; if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL mtlo: got %h/%h busy %b want 12345678/9abcdef0 busy 0", bus.hi, bus.lo, bus.busy); end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.md_op = MD_NONE;
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      miscompares++; $display("FAIL rmid_clear: got busy %b %h/%h want 0 0/0", bus.busy, bus.hi, bus.lo); end
    repeat (12) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      miscompares++; $display("FAIL rmid_nowrite: got busy %b %h/%h want 0 0/0", bus.busy, bus.hi, bus.lo); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_stall;
    int bc, sc; bit ho; logic ss, sa; exp_t x;
    run_md(MD_MULT, 32'd6, 32'd7, 1'b1, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (ss !== 1'b1) begin miscompares++; $display("FAIL stall_start: got %b want 1", ss); end
    vectors++; if (sc !== 5) begin miscompares++; $display("FAIL stall_busy: got %0d want 5", sc); end
    vectors++; if (sa !== 1'b0) begin miscompares++; $display("FAIL stall_after: got %b want 0", sa); end
    vectors++; if (bus.lo !== x.lo) begin miscompares++; $display("FAIL stall_lo: got %h want %h", bus.lo, x.lo); end
    run_md(MD_MULT, 32'd6, 32'd7, 1'b0, bc, sc, ho, ss, sa);
    x = sb.pop_front();
    vectors++; if (ss !== 1'b0 || sc !== 0 || sa !== 1'b0) begin miscompares++; $display("FAIL stall_off: got %b/%0d/%b want 0/0/0", ss, sc, sa); end
  endtask

  task automatic test_protocol;
    int bc, p0; exp_t x;
    p0 = proto_errs;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.a = 32'd3; bus.b = 32'd5;
    x.hi = 32'h0; x.lo = 32'd15; sb.push_back(x);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.md_op = MD_NONE;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      bc++;
      bus.start = (i == 1); bus.md_op = (i == 1) ? MD_DIV : MD_NONE; bus.a = 32'd100; bus.b = 32'd3;
    end
    bus.start = 1'b0; bus.md_op = MD_NONE;
    x = sb.pop_front();
    vectors++; if (bc !== 5) begin miscompares++; $display("FAIL proto_busy: got %0d want 5", bc); end
    vectors++; if (bus.hi !== x.hi || bus.lo !== x.lo) begin miscompares++; $display("FAIL proto_result: got %h/%h want %h/%h", bus.hi, bus.lo, x.hi, x.lo); end
    vectors++; if (proto_errs - p0 !== 1) begin miscompares++; $display("FAIL proto_flag: got %0d want 1", proto_errs - p0); end
    m_hi = x.hi; m_lo = x.lo;
  endtask

  task automatic test_random;
    int bc, sc, want; bit ho; logic ss, sa; exp_t x;
    logic [2:0] op; logic [31:0] a, b;
    for (int n = 0; n < 16; n++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_md(op, a, b, 1'b0, bc, sc, ho, ss, sa);
      x = sb.pop_front();
      want = (op <= 3'd2) ? 5 : 10;
      vectors++; if (bc !== want) begin miscompares++; $display("FAIL rand_busy op%0d: got %0d want %0d", op, bc, want); end
      vectors++; if (bus.hi !== x.hi || bus.lo !== x.lo) begin
        miscompares++; $display("FAIL rand_result op%0d a=%h b=%h: got %h/%h want %h/%h", op, a, b, bus.hi, bus.lo, x.hi, x.lo); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.md_op = MD_NONE; bus.a = '0; bus.b = '0; bus.d_md_use = 1'b0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_overflow;
    test_mt;
    test_reset_mid;
    test_stall;
    test_protocol;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
